// File: rtl/seg_scan_capture_if.sv
// Signal bundle between a multiplexed 7-segment scan source and its capture monitor.
// The master drives the scanned lines and error clear; the slave returns the reconstructed frame.
interface seg_scan_capture_if;
    logic [6:0]  seg_in;
    logic [7:0]  an_in;
    logic        dp_in;
    logic        err_clr;
    logic [31:0] value_out;
    logic [7:0]  dp_out;
    logic        frame_valid;
    logic        digit_stb;
    logic [2:0]  digit_idx;
    logic [3:0]  digit_val;
    logic        seg_err;
    logic        an_err;

    modport master (
        output seg_in, an_in, dp_in, err_clr,
        input  value_out, dp_out, frame_valid, digit_stb,
        input  digit_idx, digit_val, seg_err, an_err
    );

    modport slave (
        input  seg_in, an_in, dp_in, err_clr,
        output value_out, dp_out, frame_valid, digit_stb,
        output digit_idx, digit_val, seg_err, an_err
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Reader side of a multiplexed 7-segment display: synchronizes the scanned lines,
// waits for them to settle, decodes each lit digit and assembles complete 32-bit frames.
module seg_scan_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_capture_if.slave bus
);

    localparam int BW = 16;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYCLES - 1);

    // {hit, nibble} for an active-low gfedcba pattern
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic exactly_one_low(input logic [7:0] an);
        logic [7:0] lo;
        lo = ~an;
        return (lo != 8'h00) && ((lo & (lo - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    logic [BW-1:0]          sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [BW-1:0]          prev_q;
    logic                   prev_vld_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d;

    logic [BW-1:0] bus_in_s;
    logic [BW-1:0] synced_s;
    logic          synced_vld_s;
    logic          same_s;

    assign bus_in_s     = {bus.dp_in, bus.an_in, bus.seg_in};
    assign synced_s     = sync_q[SYNC_STAGES-1];
    assign synced_vld_s = fill_q[SYNC_STAGES-1];
    assign same_s       = prev_vld_q && (synced_s == prev_q);

    // Synchronizer chain; fill_q marks stages that hold post-reset samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {BW{1'b0}};
            end
            fill_q     <= {SYNC_STAGES{1'b0}};
            prev_q     <= {BW{1'b0}};
            prev_vld_q <= 1'b0;
            cnt_q      <= CNT_ZERO;
            acc_q      <= 1'b0;
        end else begin
            sync_q[0] <= bus_in_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= synced_s;
            prev_vld_q <= synced_vld_s;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
        end
    end

    // Stability counter; acc_d flags the single step into SETTLE_CYCLES
    always_comb begin
        cnt_d = cnt_q;
        acc_d = 1'b0;
        if (!synced_vld_s) begin
            cnt_d = CNT_ZERO;
        end else if (!same_s) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q < SETTLE_C) begin
            cnt_d = cnt_q + CNT_ONE;
            acc_d = (cnt_q == SETTLE_M1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    logic [31:0] value_q, value_d;
    logic [7:0]  dpo_q, dpo_d;
    logic        fv_q, fv_d;
    logic        stb_q, stb_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  val_q, val_d;
    logic        seg_err_q, seg_err_d;
    logic        an_err_q, an_err_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  bdp_q, bdp_d;
    logic [7:0]  mask_q, mask_d;

    logic [7:0] acc_an_s;
    logic [6:0] acc_seg_s;
    logic       acc_dp_s;
    logic [4:0] dec_s;
    logic [2:0] acc_idx_s;
    logic [7:0] mask_nx_s;
    logic       new_seg_err_s;
    logic       new_an_err_s;

    // prev_q still holds the settled bus during the acceptance cycle
    assign acc_an_s  = prev_q[14:7];
    assign acc_seg_s = prev_q[6:0];
    assign acc_dp_s  = prev_q[15];
    assign dec_s     = seg_decode(acc_seg_s);
    assign acc_idx_s = low_index(acc_an_s);

    // Classify the accepted sample, update frame buffer and sticky errors
    always_comb begin
        value_d       = value_q;
        dpo_d         = dpo_q;
        fv_d          = 1'b0;
        stb_d         = 1'b0;
        idx_d         = idx_q;
        val_d         = val_q;
        buf_d         = buf_q;
        bdp_d         = bdp_q;
        mask_d        = mask_q;
        mask_nx_s     = mask_q;
        new_seg_err_s = 1'b0;
        new_an_err_s  = 1'b0;
        if (acc_q) begin
            if (acc_an_s == 8'hFF) begin
                new_an_err_s = 1'b0;
            end else if (exactly_one_low(acc_an_s)) begin
                if (dec_s[4]) begin
                    stb_d                        = 1'b1;
                    idx_d                        = acc_idx_s;
                    val_d                        = dec_s[3:0];
                    buf_d[{acc_idx_s, 2'b00} +: 4] = dec_s[3:0];
                    bdp_d[acc_idx_s]             = ~acc_dp_s;
                    mask_nx_s                    = mask_q | (8'h01 << acc_idx_s);
                    if (mask_nx_s == 8'hFF) begin
                        value_d = buf_d;
                        dpo_d   = bdp_d;
                        fv_d    = 1'b1;
                        mask_d  = 8'h00;
                    end else begin
                        mask_d  = mask_nx_s;
                    end
                end else begin
                    new_seg_err_s = 1'b1;
                end
            end else begin
                new_an_err_s = 1'b1;
            end
        end else begin
            new_seg_err_s = 1'b0;
        end
        // a fresh error outranks a simultaneous clear
        seg_err_d = (bus.err_clr ? 1'b0 : seg_err_q) | new_seg_err_s;
        an_err_d  = (bus.err_clr ? 1'b0 : an_err_q)  | new_an_err_s;
    end

    // Output and frame-assembly registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= 32'h0000_0000;
            dpo_q     <= 8'h00;
            fv_q      <= 1'b0;
            stb_q     <= 1'b0;
            idx_q     <= 3'd0;
            val_q     <= 4'h0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            buf_q     <= 32'h0000_0000;
            bdp_q     <= 8'h00;
            mask_q    <= 8'h00;
        end else begin
            value_q   <= value_d;
            dpo_q     <= dpo_d;
            fv_q      <= fv_d;
            stb_q     <= stb_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
            buf_q     <= buf_d;
            bdp_q     <= bdp_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.value_out   = value_q;
    assign bus.dp_out      = dpo_q;
    assign bus.frame_valid = fv_q;
    assign bus.digit_stb   = stb_q;
    assign bus.digit_idx   = idx_q;
    assign bus.digit_val   = val_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.an_err      = an_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized bench for seg_scan_capture: a run-length reference model predicts every
// output each cycle, and directed scenarios pin the model with hand-computed values.
module tb_seg_scan_capture;

    localparam int S  = 2;
    localparam int ST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_capture_if bus_if ();

    seg_scan_capture #(.SYNC_STAGES(S), .SETTLE_CYCLES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint due; logic [15:0] v; } acc_t;
    acc_t        pend [$];
    acc_t        m_acc;
    longint      edge_no;
    logic [15:0] cur, smp;
    int          run;
    bit          have;
    logic [3:0]  m_nib [8];
    bit          m_lit [8];
    bit          m_seen [8];
    int          m_lows, m_pos, m_code;
    bit          m_all, m_ns, m_na;
    logic [7:0]  m_an;

    logic [31:0] exp_value;
    logic [7:0]  exp_dp;
    logic        exp_fv, exp_stb, exp_seg_err, exp_an_err;
    logic [2:0]  exp_idx;
    logic [3:0]  exp_val;

    // A run of ST identical input samples is one acceptance, visible S+1 edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            have = 0; run = 0; edge_no = 0; cur = 16'h0000;
            for (int i = 0; i < 8; i++) begin
                m_nib[i] = 4'h0; m_lit[i] = 0; m_seen[i] = 0;
            end
            exp_value = 32'h0; exp_dp = 8'h00; exp_fv = 1'b0; exp_stb = 1'b0;
            exp_idx = 3'd0; exp_val = 4'h0; exp_seg_err = 1'b0; exp_an_err = 1'b0;
        end else begin
            edge_no++;
            exp_fv = 1'b0; exp_stb = 1'b0; m_ns = 0; m_na = 0;
            if (pend.size() > 0 && pend[0].due == edge_no) begin
                m_acc  = pend.pop_front();
                m_an   = m_acc.v[14:7];
                m_lows = 0; m_pos = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!m_an[i]) begin m_lows++; m_pos = i; end
                end
                if (m_lows == 1) begin
                    m_code = -1;
                    for (int k = 0; k < 16; k++) if (hex_tab[k] == m_acc.v[6:0]) m_code = k;
                    if (m_code < 0) m_ns = 1;
                    else begin
                        exp_stb = 1'b1; exp_idx = 3'(m_pos); exp_val = 4'(m_code);
                        m_nib[m_pos] = 4'(m_code); m_lit[m_pos] = !m_acc.v[15]; m_seen[m_pos] = 1;
                        m_all = 1;
                        for (int i = 0; i < 8; i++) if (!m_seen[i]) m_all = 0;
                        if (m_all) begin
                            for (int i = 0; i < 8; i++) begin
                                exp_value[4*i +: 4] = m_nib[i];
                                exp_dp[i] = m_lit[i];
                                m_seen[i] = 0;
                            end
                            exp_fv = 1'b1;
                        end
                    end
                end else if (m_lows > 1) m_na = 1;
            end
            if (bus_if.err_clr) begin exp_seg_err = 1'b0; exp_an_err = 1'b0; end
            if (m_ns) exp_seg_err = 1'b1;
            if (m_na) exp_an_err = 1'b1;
            smp = {bus_if.dp_in, bus_if.an_in, bus_if.seg_in};
            if (have && smp == cur) run++;
            else begin cur = smp; run = 1; have = 1; end
            if (run == ST) pend.push_back('{edge_no + S + 1, smp});
        end
    end

    // ---------------- per-cycle compare ----------------
    int         stb_cnt = 0, fv_cnt = 0;
    logic [2:0] last_idx = 3'd0;
    logic [3:0] last_val = 4'h0;

    always @(negedge clk) begin
        chk("value_out",   bus_if.value_out,   exp_value);
        chk("dp_out",      {24'h0, bus_if.dp_out}, {24'h0, exp_dp});
        chk("frame_valid", {31'h0, bus_if.frame_valid}, {31'h0, exp_fv});
        chk("digit_stb",   {31'h0, bus_if.digit_stb},   {31'h0, exp_stb});
        chk("seg_err",     {31'h0, bus_if.seg_err},     {31'h0, exp_seg_err});
        chk("an_err",      {31'h0, bus_if.an_err},      {31'h0, exp_an_err});
        if (exp_stb) begin
            chk("digit_idx", {29'h0, bus_if.digit_idx}, {29'h0, exp_idx});
            chk("digit_val", {28'h0, bus_if.digit_val}, {28'h0, exp_val});
        end
        if (bus_if.digit_stb === 1'b1) begin
            stb_cnt++; last_idx = bus_if.digit_idx; last_val = bus_if.digit_val;
        end
        if (bus_if.frame_valid === 1'b1) fv_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.an_in = 8'hFF; bus_if.seg_in = 7'h7F; bus_if.dp_in = 1'b1;
        repeat (n) tick();
    endtask

    // Driver-style digit: anode switches first, segments follow one cycle later
    task automatic scan_digit(input int i, input logic [31:0] x, input logic [7:0] dpm,
                              input int period, input int glitch);
        logic [7:0] one;
        logic [3:0] nib;
        one = 8'h01;
        nib = x[4*i +: 4];
        bus_if.an_in = ~(one << i);
        bus_if.dp_in = ~dpm[i];
        tick();
        bus_if.seg_in = hex_tab[nib];
        if (glitch > 0) begin
            repeat (2) tick();
            bus_if.seg_in = 7'($urandom);
            repeat (glitch) tick();
            bus_if.seg_in = hex_tab[nib];
            repeat (period - 3 - glitch) tick();
        end else begin
            repeat (period - 1) tick();
        end
    endtask

    task automatic scan_frame(input logic [31:0] x, input logic [7:0] dpm, input int period);
        for (int i = 0; i < 8; i++) scan_digit(i, x, dpm, period, 0);
    endtask

    int fv0, stb0, per, gl;
    logic [31:0] rx;
    logic [7:0]  rdp;

    initial begin
        bus_if.an_in = 8'hFF; bus_if.seg_in = 7'h7F; bus_if.dp_in = 1'b1; bus_if.err_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset value_out", bus_if.value_out, 32'h0);
        chk("reset flags", {28'h0, bus_if.frame_valid, bus_if.digit_stb, bus_if.seg_err, bus_if.an_err}, 32'h0);
        idle(5);

        // Full scan at 64 cycles per digit
        fv0 = fv_cnt;
        scan_frame(32'h89AB_CDEF, 8'h00, 64);
        idle(10);
        chk("t1 value", bus_if.value_out, 32'h89AB_CDEF);
        chk("t1 frames", 32'(fv_cnt - fv0), 32'd1);

        // Value changes mid-frame
        for (int i = 0; i < 4; i++) scan_digit(i, 32'h0123_4567, 8'h00, 16, 0);
        for (int i = 4; i < 8; i++) scan_digit(i, 32'hFFFF_0000, 8'h00, 16, 0);
        idle(8);
        chk("t2 mixed", bus_if.value_out, 32'hFFFF_4567);
        scan_frame(32'hFFFF_0000, 8'h00, 16);
        idle(8);
        chk("t2 full", bus_if.value_out, 32'hFFFF_0000);

        // Unsettled segments produce nothing; a settled 2 produces one strobe
        stb0 = stb_cnt;
        bus_if.an_in = 8'hFE;
        for (int k = 0; k < 8; k++) begin
            bus_if.seg_in = (k % 2 == 0) ? 7'h40 : 7'h79;
            repeat (2) tick();
        end
        chk("t3 no strobe", 32'(stb_cnt - stb0), 32'd0);
        bus_if.seg_in = 7'h24;
        repeat (10) tick();
        idle(6);
        chk("t3 one strobe", 32'(stb_cnt - stb0), 32'd1);
        chk("t3 idx", {29'h0, last_idx}, 32'd0);
        chk("t3 val", {28'h0, last_val}, 32'd2);

        // Two anodes low, with err_clr landing on the same edge as the error
        stb0 = stb_cnt;
        bus_if.an_in = 8'hFC; bus_if.seg_in = 7'h40;
        repeat (6) tick();
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        repeat (4) tick();
        chk("t4 an_err set", {31'h0, bus_if.an_err}, 32'd1);
        chk("t4 no strobe", 32'(stb_cnt - stb0), 32'd0);
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        tick();
        chk("t4 an_err clr", {31'h0, bus_if.an_err}, 32'd0);
        bus_if.an_in = 8'hFE; bus_if.seg_in = 7'h7F;
        repeat (10) tick();
        chk("t4 seg_err", {31'h0, bus_if.seg_err}, 32'd1);
        idle(6);

        // Decimal point on digit 4 only
        scan_frame(32'h1357_9BDF, 8'h10, 12);
        idle(8);
        chk("t5 dp_out", {24'h0, bus_if.dp_out}, 32'h10);
        chk("t5 value", bus_if.value_out, 32'h1357_9BDF);

        // Reset after five digits discards the partial frame
        for (int i = 0; i < 5; i++) scan_digit(i, 32'h7654_3210, 8'h00, 12, 0);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("t6 value after reset", bus_if.value_out, 32'h0);
        fv0 = fv_cnt;
        for (int i = 0; i < 7; i++) scan_digit(i, 32'h2468_ACE0, 8'h00, 12, 0);
        chk("t6 no early frame", 32'(fv_cnt - fv0), 32'd0);
        chk("t6 value held", bus_if.value_out, 32'h0);
        scan_digit(7, 32'h2468_ACE0, 8'h00, 12, 0);
        idle(8);
        chk("t6 frame", bus_if.value_out, 32'h2468_ACE0);

        // Randomized scans with glitches, bad patterns and error clears
        for (int f = 0; f < 14; f++) begin
            rx  = $urandom;
            rdp = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                per = $urandom_range(20, 8);
                gl  = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
                scan_digit(i, rx, rdp, per, gl);
            end
            if ($urandom_range(2, 0) == 0) begin
                bus_if.an_in  = 8'($urandom) & 8'h7E;
                bus_if.seg_in = 7'($urandom);
                repeat ($urandom_range(7, 2)) tick();
            end
            if ($urandom_range(1, 0) == 0) begin
                bus_if.an_in  = 8'hFF ^ (8'h01 << $urandom_range(7, 0));
                bus_if.seg_in = 7'($urandom);
                repeat ($urandom_range(7, 3)) tick();
            end
            if ($urandom_range(2, 0) == 0) begin
                bus_if.err_clr = 1'b1;
                tick();
                bus_if.err_clr = 1'b0;
            end
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
